// File: rtl/mem_dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dcache_pkg
//  Description : Shared widths, geometry and FSM state encoding for the
//                MEM-stage data cache (mem_dcache and dcache_array).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_dcache_pkg;

    localparam int          DATA_WID     = 32;
    localparam int          ADDR_WID     = 32;
    localparam int          BE_WID       = DATA_WID / 8;
    localparam int          DCACHE_IDX_W = 8;
    localparam logic [3:0]  MMIO_NIB     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,   // line refill or uncached read
        ST_WRITE = 2'd2    // write-through
    } dcache_state_t;

endpackage : mem_dcache_pkg
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_array
//  Description : Tag, data and valid storage for the direct-mapped data cache.
//                Asynchronous read, synchronous byte-enabled data write,
//                tag/valid written on a line fill, valid bits cleared in a
//                single cycle by rst.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                rd_idx            - lookup index
//                rd_data/rd_tag/rd_valid - contents of the indexed line
//                wr_en/wr_idx      - write strobe and line index
//                wr_be/wr_data     - per-byte enables and data
//                wr_fill/wr_tag    - fill: also write tag and set valid
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_array #(
    parameter int IDX_W  = 8,
    parameter int TAG_W  = 30 - IDX_W,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_fill,
    input  logic [TAG_W-1:0]    wr_tag
);

    localparam int LINES = 1 << IDX_W;

    logic [DATA_W-1:0] r_data_mem [LINES];
    logic [TAG_W-1:0]  r_tag_mem  [LINES];
    logic [LINES-1:0]  r_valid;

    assign rd_data  = r_data_mem[rd_idx];
    assign rd_tag   = r_tag_mem[rd_idx];
    assign rd_valid = r_valid[rd_idx];

    // Reset wins over any write so an abandoned refill never lands.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_be[b]) begin
                    r_data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en && wr_fill) begin
            r_tag_mem[wr_idx] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (wr_en && wr_fill) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

endmodule : dcache_array
`default_nettype wire

// File: rtl/mem_dcache.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dcache
//  Description : MEM-stage L1 data cache. Direct-mapped, one word per line,
//                write-through, no-write-allocate. Addresses whose top nibble
//                equals MMIO_NIB bypass the cache.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                cpu_rd/cpu_wr/cpu_addr/cpu_wdata/cpu_be - CPU request
//                cpu_rdata, dcache_stall       - load data, pipeline stall
//                mem_req/mem_we/mem_addr/mem_wdata/mem_be - memory request
//                mem_ack/mem_rdata             - memory completion and data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dcache #(
    parameter int         IDX_W    = mem_dcache_pkg::DCACHE_IDX_W,
    parameter logic [3:0] MMIO_NIB = mem_dcache_pkg::MMIO_NIB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        dcache_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    import mem_dcache_pkg::*;

    localparam int TAG_W = ADDR_WID - IDX_W - 2;

    dcache_state_t r_state;
    dcache_state_t w_next;

    // Captured request; held stable for the whole memory transaction.
    logic [ADDR_WID-3:0] r_word_addr;
    logic                r_we;
    logic [DATA_WID-1:0] r_wdata;
    logic [BE_WID-1:0]   r_be;
    logic                r_mmio;

    logic [IDX_W-1:0]    w_cpu_idx;
    logic [TAG_W-1:0]    w_cpu_tag;
    logic                w_cpu_mmio;
    logic                w_hit;
    logic                w_capture;

    logic [DATA_WID-1:0] w_line_data;
    logic [TAG_W-1:0]    w_line_tag;
    logic                w_line_valid;

    logic                w_arr_we;
    logic [IDX_W-1:0]    w_arr_idx;
    logic [BE_WID-1:0]   w_arr_be;
    logic [DATA_WID-1:0] w_arr_wdata;
    logic                w_arr_fill;
    logic [TAG_W-1:0]    w_arr_tag;

    logic                w_unused_addr_lsb;

    assign w_cpu_idx         = cpu_addr[IDX_W+1:2];
    assign w_cpu_tag         = cpu_addr[ADDR_WID-1:IDX_W+2];
    assign w_cpu_mmio        = (cpu_addr[31:28] == MMIO_NIB);
    assign w_hit             = w_line_valid && (w_line_tag == w_cpu_tag) && !w_cpu_mmio;
    assign w_unused_addr_lsb = ^cpu_addr[1:0];

    dcache_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_WID)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (w_cpu_idx),
        .rd_data  (w_line_data),
        .rd_tag   (w_line_tag),
        .rd_valid (w_line_valid),
        .wr_en    (w_arr_we),
        .wr_idx   (w_arr_idx),
        .wr_be    (w_arr_be),
        .wr_data  (w_arr_wdata),
        .wr_fill  (w_arr_fill),
        .wr_tag   (w_arr_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        dcache_stall = 1'b0;
        cpu_rdata    = '0;
        w_capture    = 1'b0;
        w_arr_we     = 1'b0;
        w_arr_idx    = w_cpu_idx;
        w_arr_be     = cpu_be;
        w_arr_wdata  = cpu_wdata;
        w_arr_fill   = 1'b0;
        w_arr_tag    = w_cpu_tag;

        unique case (r_state)
            ST_IDLE: begin
                // A simultaneous load and store is handled as a store.
                if (cpu_wr) begin
                    dcache_stall = 1'b1;
                    w_capture    = 1'b1;
                    w_next       = ST_WRITE;
                    // Write hit updates the line now; a miss does not allocate.
                    w_arr_we     = w_hit;
                end else if (cpu_rd) begin
                    if (w_hit) begin
                        cpu_rdata = w_line_data;
                    end else begin
                        dcache_stall = 1'b1;
                        w_capture    = 1'b1;
                        w_next       = ST_READ;
                    end
                end
            end

            ST_READ: begin
                dcache_stall = !mem_ack;
                if (mem_ack) begin
                    cpu_rdata   = mem_rdata;
                    w_next      = ST_IDLE;
                    w_arr_we    = !r_mmio;
                    w_arr_fill  = 1'b1;
                    w_arr_idx   = r_word_addr[IDX_W-1:0];
                    w_arr_tag   = r_word_addr[ADDR_WID-3:IDX_W];
                    w_arr_be    = '1;
                    w_arr_wdata = mem_rdata;
                end
            end

            ST_WRITE: begin
                dcache_stall = !mem_ack;
                if (mem_ack) begin
                    w_next = ST_IDLE;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_addr <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_mmio      <= 1'b0;
        end else if (w_capture) begin
            r_word_addr <= cpu_addr[ADDR_WID-1:2];
            r_we        <= cpu_wr;
            r_wdata     <= cpu_wr ? cpu_wdata : '0;
            r_be        <= cpu_wr ? cpu_be : '0;
            r_mmio      <= w_cpu_mmio;
        end
    end

    assign mem_req   = (r_state != ST_IDLE);
    assign mem_we    = r_we;
    assign mem_addr  = {r_word_addr, 2'b00};
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

endmodule : mem_dcache
`default_nettype wire

// File: doc/mem_dcache.md
Name: mem_dcache

Overview:
- Data-side L1 cache for the MEM stage. Direct-mapped, one 32-bit word per line, write-through, no-write-allocate.
- Sits between the EX/MEM pipeline register and the external data memory or MMIO bus.
- Supplies load data, and the `dcache_stall` that MEM_WB uses to insert a bubble.
- Addresses in the MMIO window bypass the cache.

Parameters:
- `IDX_W`, 8: index bits; line count = 2^IDX_W (256 words).
- `MMIO_NIB`, 4'hF: `cpu_addr[31:28]` value marking the uncached MMIO window.

Ports:
- `clk` in 1: clock
- `rst` in 1: reset
- `cpu_rd` in 1: load request (held until `dcache_stall` low)
- `cpu_wr` in 1: store request (held until `dcache_stall` low)
- `cpu_addr` in 32: byte address; bits [1:0] ignored
- `cpu_wdata` in 32: store data, already lane-aligned
- `cpu_be` in 4: store byte enables
- `cpu_rdata` out 32: load data, full word
- `dcache_stall` out 1: request not complete this cycle
- `mem_req` out 1: memory request
- `mem_we` out 1: 1 = write, 0 = read
- `mem_addr` out 32: word-aligned address
- `mem_wdata` out 32: write data
- `mem_be` out 4: write byte enables
- `mem_ack` in 1: one-cycle completion pulse
- `mem_rdata` in 32: read data, valid with `mem_ack`

Behaviour:
- Reset: `rst` is synchronous, active-high; clock is `clk`. On reset:
  - all valid bits clear, state = IDLE;
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` = 0;
  - `cpu_rdata` = 0 and `dcache_stall` = 0 when no request is present.
- Address split: tag = `cpu_addr[31:IDX_W+2]`, index = `cpu_addr[IDX_W+1:2]`.
  - hit = valid[idx] && tag match && not MMIO.
- States: IDLE, READ (refill or uncached read), WRITE (write-through).
- IDLE:
  - Read hit: `cpu_rdata` = line data combinationally, stall = 0, zero extra latency.
  - Read miss or MMIO read: stall = 1. Capture addr in `mem_addr` (word-aligned), go to READ.
  - Write: stall = 1. Capture addr, `cpu_wdata`, `cpu_be`, set `mem_we` = 1, go to WRITE.
    - On hit (non-MMIO), merge enabled bytes into the line in that same cycle.
    - On miss, do not allocate.
  - `cpu_rd` and `cpu_wr` both high: treated as a write.
- READ:
  - `mem_req` = 1, stall = !`mem_ack`.
  - On `mem_ack`: `cpu_rdata` = `mem_rdata` (bypass). Unless MMIO, write the line (data, tag, valid=1). Next state IDLE.
- WRITE:
  - `mem_req` = 1, stall = !`mem_ack`. On `mem_ack`, next state IDLE.
- Handshake:
  - `mem_req` = (state != IDLE).
  - `mem_addr`, `mem_we`, `mem_wdata`, `mem_be` are stable from the first `mem_req` cycle through the ack cycle.
  - `mem_req` drops the cycle after ack. There is at least one IDLE cycle between consecutive memory transactions.
- Latency:
  - Miss detected in cycle 0; `mem_req` first high in cycle 1.
  - Ack in cycle k gives stall low and data valid in cycle k.
  - The CPU request is consumed at the edge ending cycle k.
- Other rules:
  - `mem_ack` in IDLE is ignored.
  - `cpu_rdata` while stall = 1 is don't-care; the bench must not check it.
  - Write hit and a later read of the same index: the read sees the merged data.
- Reset mid-transaction: state → IDLE, `mem_req` drops the next cycle, the line is not updated, all lines are invalidated. The memory side must tolerate the abandoned request.
- Arrays:
  - Data array: 2^IDX_W x 32, written with per-byte enables.
  - Tag array: 2^IDX_W x (30−IDX_W).
  - Valid: 2^IDX_W flops, cleared in one cycle on reset.

Decomposition:
- Shared const/package entries: `DATA_WID`, `ADDR_WID`, `DCACHE_IDX_W`, `MMIO_NIB`, and the state enum (IDLE/READ/WRITE).
- One sub-module, `dcache_array`:
  - tag, data and valid storage;
  - async read, sync byte-enabled write, synchronous valid clear.
- The FSM and handshake logic stay in `mem_dcache`.

Test Plan:
- Cold read 0x0000_0040, memory acks 3 cycles after `mem_req` with 0xDEADBEEF → stall high 4 cycles, `cpu_rdata` = 0xDEADBEEF on the ack cycle. Re-read the next request → hit, stall 0, 0xDEADBEEF.
- Store 0x0000_0040, `cpu_be` = 4'b0011, data 0x0000_1234, after the prior fill → `mem_req`/`mem_we`=1, `mem_be` = 4'b0011 until ack. Subsequent read hits and returns 0xDEAD1234.
- Conflict: read 0x0000_0040 then 0x0000_0440 (same index, different tag) → second misses and refills. Re-reading 0x40 misses again.
- MMIO read 0xF000_0000 twice, acks with 0x11 then 0x22 → both go to memory, returns 0x11 then 0x22, no allocation.
- Store miss to 0x0000_0080 → write-through only. Following read of 0x80 misses.
- `rst` asserted during READ before ack → `mem_req` 0 the next cycle, state IDLE, the previously cached 0x40 now misses.
